// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    REFILL
  } cache_state_t;

  localparam int TAG_W      = 22;
  localparam int IDX_W      = 5;
  localparam int OFS_W      = 5;
  localparam int BLOCK_BITS = 256;
  localparam int WORD_W     = 32;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  // One-word write enable inside a line, selected by the word index.
  function automatic logic [BLOCK_BITS-1:0] word_mask(input logic [2:0] sel);
    logic [BLOCK_BITS-1:0] m;
    m = '0;
    m[sel*WORD_W +: WORD_W] = '1;
    return m;
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side bus of the data cache, named from the cache's view.
interface dcache_ctrl_if #(
  parameter int ADDR_W     = 32,
  parameter int BLOCK_BITS = 256
);
  logic                  req_i;
  logic                  we_i;
  logic [ADDR_W-1:0]     addr_i;
  logic [31:0]           wdata_i;
  logic [31:0]           rdata_o;
  logic                  stall_o;
  logic                  mem_enable_o;
  logic                  mem_write_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [BLOCK_BITS-1:0] mem_wdata_o;
  logic                  mem_ack_i;
  logic [BLOCK_BITS-1:0] mem_rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
    output rdata_o, stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
    input  rdata_o, stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_sram.sv
// Tag and data arrays: asynchronous read, synchronous masked write,
// valid/dirty bits cleared asynchronously so stale lines never hit after reset.
module dcache_sram
  import cache_pkg::*;
#(
  parameter int LINES = 32,
  parameter int BITS  = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [$clog2(LINES)-1:0] idx_i,
  output tag_entry_t               entry_o,
  output logic [BITS-1:0]          data_o,
  input  logic                     tag_we_i,
  input  tag_entry_t               entry_i,
  input  logic [BITS-1:0]          data_mask_i,
  input  logic [BITS-1:0]          data_i
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [BITS-1:0]  data_q [LINES];

  // Status bits: the only state that needs reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (tag_we_i) begin
      valid_q[idx_i] <= entry_i.valid;
      dirty_q[idx_i] <= entry_i.dirty;
    end
  end

  // Tag and data storage; contents are meaningless while valid is clear.
  always_ff @(posedge clk_i) begin
    if (tag_we_i) begin
      tag_q[idx_i] <= entry_i.tag;
    end
    if (|data_mask_i) begin
      data_q[idx_i] <= (data_q[idx_i] & ~data_mask_i) | (data_i & data_mask_i);
    end
  end

  assign entry_o = {valid_q[idx_i], dirty_q[idx_i], tag_q[idx_i]};
  assign data_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller: hit logic,
// word select and merge, refill register and the miss-handling FSM.
//
// state     | meaning
// IDLE      | serve hits with no stall; a miss raises stall and leaves
// WRITEBACK | write the dirty victim block to memory, wait for ack
// ALLOCATE  | read the missing block from memory, capture it on ack
// REFILL    | install the captured block as a clean valid line
module dcache_ctrl
  import cache_pkg::*;
#(
  parameter int LINES      = 32,
  parameter int BLOCK_BITS = 256,
  parameter int ADDR_W     = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dcache_ctrl_if.slave  bus
);

  localparam int IDX_L = $clog2(LINES);
  localparam int WORDS = BLOCK_BITS / WORD_W;
  localparam int SEL_W = $clog2(WORDS);

  cache_state_t state_q, state_d;
  logic [BLOCK_BITS-1:0] refill_q;

  logic [IDX_L-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [SEL_W-1:0]      wsel;
  tag_entry_t            rd_entry;
  logic [BLOCK_BITS-1:0] rd_data;
  logic                  hit;

  logic                  tag_we;
  tag_entry_t            wr_entry;
  logic [BLOCK_BITS-1:0] wr_mask;
  logic [BLOCK_BITS-1:0] wr_data;

  logic                  stall;
  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_W-1:0]     mem_addr;
  logic [BLOCK_BITS-1:0] mem_wdata;
  logic [31:0]           rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.addr_i[1:0];

  assign idx  = bus.addr_i[OFS_W +: IDX_L];
  assign tag  = bus.addr_i[ADDR_W-1 -: TAG_W];
  assign wsel = bus.addr_i[2 +: SEL_W];
  assign hit  = rd_entry.valid & (rd_entry.tag == tag);

  dcache_sram #(
    .LINES (LINES),
    .BITS  (BLOCK_BITS)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (idx),
    .entry_o     (rd_entry),
    .data_o      (rd_data),
    .tag_we_i    (tag_we),
    .entry_i     (wr_entry),
    .data_mask_i (wr_mask),
    .data_i      (wr_data)
  );

  // State register; reset aborts any miss in flight without touching the arrays.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Refill block is captured in the ack cycle, installed one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                  refill_q <= '0;
    else if (state_q == ALLOCATE && bus.mem_ack_i) refill_q <= bus.mem_rdata_i;
  end

  // Next state, array writes and bus outputs.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rdata     = '0;
    tag_we    = 1'b0;
    wr_entry  = '0;
    wr_mask   = '0;
    wr_data   = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          if (hit) begin
            if (bus.we_i) begin
              wr_mask[wsel*WORD_W +: WORD_W] = '1;
              wr_data  = {WORDS{bus.wdata_i}};
              tag_we   = 1'b1;
              wr_entry = '{valid: 1'b1, dirty: 1'b1, tag: tag};
            end else begin
              rdata = rd_data[wsel*WORD_W +: WORD_W];
            end
          end else begin
            stall   = 1'b1;
            state_d = (rd_entry.valid & rd_entry.dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {rd_entry.tag, idx, {OFS_W{1'b0}}};
        mem_wdata = rd_data;
        if (bus.mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        stall    = 1'b1;
        mem_en   = 1'b1;
        mem_addr = {bus.addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        if (bus.mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        stall    = 1'b1;
        wr_mask  = '1;
        wr_data  = refill_q;
        tag_we   = 1'b1;
        wr_entry = '{valid: 1'b1, dirty: 1'b0, tag: tag};
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // While reset is held an IDLE miss must not show up as a stall.
  assign bus.stall_o      = stall & ~rst_i;
  assign bus.mem_enable_o = mem_en;
  assign bus.mem_write_o  = mem_wr;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_wdata_o  = mem_wdata;
  assign bus.rdata_o      = rdata;

endmodule
